// File: rtl/xbar_pkg.sv
// xbar_pkg: shared op, drive-mode and state types for the crossbar op sequencer.
package xbar_pkg;
  localparam int XBAR_COL_W = 5;
  typedef enum logic [1:0] {XOP_INIT, XOP_NOT, XOP_NOR, XOP_RSVD} xop_e;
  typedef enum logic [1:0] {XM_OFF, XM_INIT, XM_EVAL} xmode_e;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_INIT, ST_EVAL} xstate_e;
endpackage

// File: rtl/xbar_op_sequencer.sv
// xbar_op_sequencer: turns column-op commands into tick-aligned INIT/EVAL crossbar drive phases.
module xbar_op_sequencer
  import xbar_pkg::*;
#(
  parameter int COL_W      = XBAR_COL_W,
  parameter int INIT_TICKS = 1,
  parameter int EVAL_TICKS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             xbar_tick,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [COL_W-1:0] cmd_src_a,
  input  logic [COL_W-1:0] cmd_src_b,
  input  logic [COL_W-1:0] cmd_dst,
  output logic             xbar_en,
  output logic [1:0]       xbar_mode,
  output logic [COL_W-1:0] xbar_col_a,
  output logic [COL_W-1:0] xbar_col_b,
  output logic [COL_W-1:0] xbar_col_dst,
  output logic             xbar_use_b,
  output logic             done,
  output logic             err
);
  localparam int MAX_T = INIT_TICKS > EVAL_TICKS ? INIT_TICKS : EVAL_TICKS;
  localparam int CNT_W = $clog2(MAX_T + 1);
  xstate_e state;
  xop_e op;
  logic [CNT_W-1:0] cnt;
  logic rej, last;
  always_comb begin
    rej = cmd_op == XOP_RSVD || (cmd_op != XOP_INIT && cmd_dst == cmd_src_a)
          || (cmd_op == XOP_NOR && cmd_dst == cmd_src_b);
    last = cnt == (state == ST_INIT ? CNT_W'(INIT_TICKS - 1) : CNT_W'(EVAL_TICKS - 1));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      op <= XOP_INIT;
      cnt <= '0;
      cmd_ready <= 1'b0;
      xbar_en <= 1'b0;
      xbar_mode <= XM_OFF;
      xbar_col_a <= '0;
      xbar_col_b <= '0;
      xbar_col_dst <= '0;
      xbar_use_b <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        ST_IDLE:
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (rej) err <= 1'b1;
            else begin
              state <= ST_WAIT;
              op <= xop_e'(cmd_op);
              xbar_col_a <= cmd_src_a;
              xbar_col_b <= cmd_src_b;
              xbar_col_dst <= cmd_dst;
            end
          end else cmd_ready <= 1'b1;
        ST_WAIT:
          if (xbar_tick) begin
            state <= ST_INIT;
            cnt <= '0;
            xbar_en <= 1'b1;
            xbar_mode <= XM_INIT;
          end
        ST_INIT, ST_EVAL:
          if (xbar_tick) begin
            if (!last) cnt <= cnt + 1'b1;
            // INIT flows straight into EVAL on the same edge so the drivers never drop out
            else if (state == ST_INIT && op != XOP_INIT) begin
              state <= ST_EVAL;
              cnt <= '0;
              xbar_mode <= XM_EVAL;
              xbar_use_b <= op == XOP_NOR;
            end else begin
              state <= ST_IDLE;
              cmd_ready <= 1'b1;
              done <= 1'b1;
              xbar_en <= 1'b0;
              xbar_mode <= XM_OFF;
              xbar_use_b <= 1'b0;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_xbar_op_sequencer.sv
// tb_xbar_op_sequencer: directed checks of phase timing, reject, tick alignment and reset abort.
module tb_xbar_op_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, xbar_tick = 1'b0, cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [1:0] cmd_op = 2'd0;
  logic [4:0] src_a = '0, src_b = '0, dst = '0;
  logic cmd_ready, xbar_en, xbar_use_b, done, err;
  logic [1:0] xbar_mode;
  logic [4:0] col_a, col_b, col_dst;
  logic cmd_ready2, xbar_en2, xbar_use_b2, done2, err2;
  logic [1:0] xbar_mode2;
  logic [4:0] col_a2, col_b2, col_dst2;
  int div = 0, n_chk = 0, n_fail = 0;

  xbar_op_sequencer dut (
    .clk(clk), .rst_n(rst_n), .xbar_tick(xbar_tick), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(src_a), .cmd_src_b(src_b), .cmd_dst(dst), .xbar_en(xbar_en),
    .xbar_mode(xbar_mode), .xbar_col_a(col_a), .xbar_col_b(col_b), .xbar_col_dst(col_dst),
    .xbar_use_b(xbar_use_b), .done(done), .err(err)
  );

  xbar_op_sequencer #(.INIT_TICKS(2), .EVAL_TICKS(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .xbar_tick(xbar_tick), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_src_a(src_a), .cmd_src_b(src_b), .cmd_dst(dst), .xbar_en(xbar_en2),
    .xbar_mode(xbar_mode2), .xbar_col_a(col_a2), .xbar_col_b(col_b2), .xbar_col_dst(col_dst2),
    .xbar_use_b(xbar_use_b2), .done(done2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // divider model: tick high for one cycle in every ten
  task automatic step();
    @(negedge clk);
    div = div == 9 ? 0 : div + 1;
    xbar_tick = div == 0;
  endtask

  task automatic send(input int op, input int a, input int b, input int d);
    cmd_op = 2'(op);
    src_a = 5'(a);
    src_b = 5'(b);
    dst = 5'(d);
    cmd_valid = 1'b1;
  endtask

  task automatic wait_tick();
    int k = 0;
    while (!xbar_tick && k < 20) begin
      step();
      k++;
    end
    check("tick_seen", int'(xbar_tick), 1);
  endtask

  initial begin
    int n;
    int dones;
    int saw_eval;
    repeat (3) step();
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_en", int'(xbar_en), 0);
    check("rst_mode", int'(xbar_mode), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", int'(cmd_ready), 1);

    // NOR 3,7 -> 12 with default phase lengths
    send(2, 3, 7, 12);
    step();
    cmd_valid = 1'b0;
    check("nor_acc_ready", int'(cmd_ready), 0);
    wait_tick();
    for (int i = 1; i <= 32; i++) begin
      step();
      check($sformatf("nor_mode@%0d", i), int'(xbar_mode), i <= 10 ? 1 : i <= 30 ? 2 : 0);
      check($sformatf("nor_en@%0d", i), int'(xbar_en), int'(i <= 30));
      check($sformatf("nor_useb@%0d", i), int'(xbar_use_b), int'(i >= 11 && i <= 30));
      check($sformatf("nor_done@%0d", i), int'(done), int'(i == 31));
      if (i <= 31) begin
        check($sformatf("nor_cols@%0d", i), int'({col_a, col_b, col_dst}), int'({5'd3, 5'd7, 5'd12}));
      end
      if (i == 31) check("nor_ready_at_done", int'(cmd_ready), 1);
    end

    // NOT with dst == src_a is rejected; the next command goes in two cycles later
    send(1, 9, 0, 9);
    step();
    check("rej_err", int'(err), 1);
    check("rej_ready", int'(cmd_ready), 0);
    check("rej_en", int'(xbar_en), 0);
    send(0, 0, 0, 5);
    step();
    check("rej_err_clear", int'(err), 0);
    check("rej_ready_back", int'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    check("init_acc_ready", int'(cmd_ready), 0);
    check("init_acc_err", int'(err), 0);
    check("init_en_wait", int'(xbar_en), 0);

    // INIT op: done 11 cycles after the first post-accept tick, never in EVAL
    wait_tick();
    n = 0;
    saw_eval = 0;
    do begin
      step();
      n++;
      if (xbar_mode == 2'd2) saw_eval = 1;
    end while (!done && n < 40);
    check("init_latency", n, 11);
    check("init_no_eval", saw_eval, 0);
    check("init_dst", int'(col_dst), 5);

    // accept in a tick cycle: that tick does not start INIT
    wait_tick();
    send(2, 1, 2, 4);
    step();
    cmd_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step();
      check($sformatf("coinc_mode@%0d", j), int'(xbar_mode), j == 10 ? 1 : 0);
    end

    // reset pulse mid-EVAL aborts with no done
    repeat (15) step();
    check("abort_pre_mode", int'(xbar_mode), 2);
    rst_n = 1'b0;
    step();
    check("abort_en", int'(xbar_en), 0);
    check("abort_mode", int'(xbar_mode), 0);
    check("abort_done", int'(done), 0);
    check("abort_useb", int'(xbar_use_b), 0);
    check("abort_ready", int'(cmd_ready), 0);
    rst_n = 1'b1;
    step();
    check("abort_ready_back", int'(cmd_ready), 1);
    check("abort_en_after", int'(xbar_en), 0);
    dones = 0;
    repeat (40) begin
      step();
      if (done || xbar_en) dones++;
    end
    check("abort_no_done", dones, 0);

    // longer phases: INIT_TICKS=2, EVAL_TICKS=3
    check("p2_ready", int'(cmd_ready2), 1);
    cmd_op = 2'd2;
    src_a = 5'd3;
    src_b = 5'd7;
    dst = 5'd12;
    cmd_valid2 = 1'b1;
    step();
    cmd_valid2 = 1'b0;
    check("p2_acc_ready", int'(cmd_ready2), 0);
    wait_tick();
    for (int i = 1; i <= 52; i++) begin
      step();
      check($sformatf("p2_mode@%0d", i), int'(xbar_mode2), i <= 20 ? 1 : i <= 50 ? 2 : 0);
      check($sformatf("p2_done@%0d", i), int'(done2), int'(i == 51));
      check($sformatf("p2_useb@%0d", i), int'(xbar_use_b2), int'(i >= 21 && i <= 50));
      check($sformatf("p2_en@%0d", i), int'(xbar_en2), int'(i <= 50));
      check($sformatf("p2_err@%0d", i), int'(err2), 0);
      if (i == 1) check("p2_cols", int'({col_a2, col_b2, col_dst2}), int'({5'd3, 5'd7, 5'd12}));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
